// File: rtl/fpu_issue_ctrl.sv
// ============================================================================
// fpu_issue_ctrl : FP issue stage - holds one decoded op, picks its unit and
//                  releases it when the unit and the FP writeback port are free
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fpu_issue_ctrl #(
  parameter int FMA_LAT  = 3,
  parameter int FAST_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_inst,
  input  logic [13:0]      io_in_sigs,
  input  logic             io_kill,
  input  logic             io_divsqrt_rdy,
  output logic             io_iss_valid,
  output logic [1:0]       io_iss_unit,
  output logic [31:0]      io_iss_inst,
  output logic [13:0]      io_iss_sigs,
  output logic             io_wb_port_bsy,
  output logic [CNT_W-1:0] io_stall_cnt
);

  localparam logic [1:0] UNIT_FMA  = 2'd0;
  localparam logic [1:0] UNIT_FAST = 2'd1;
  localparam logic [1:0] UNIT_DIV  = 2'd2;
  localparam logic [1:0] UNIT_TINT = 2'd3;

  localparam int SIG_WEN   = 13;
  localparam int SIG_TOINT = 5;
  localparam int SIG_FMA   = 3;
  localparam int SIG_DIV   = 2;
  localparam int SIG_SQRT  = 1;

  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic [13:0]      sigs_q, sigs_d;
  logic [1:0]       unit_q, unit_d;
  logic [FMA_LAT:0] sched_q, sched_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [1:0] w_in_unit;
  logic       w_pipelined;
  logic       w_sched_hit;
  logic       w_hazard;
  logic       w_fire;
  logic       w_capture;

  always_comb begin
    w_in_unit = UNIT_FAST;
    if (io_in_sigs[SIG_DIV] || io_in_sigs[SIG_SQRT]) begin
      w_in_unit = UNIT_DIV;
    end else if (io_in_sigs[SIG_FMA]) begin
      w_in_unit = UNIT_FMA;
    end else if (io_in_sigs[SIG_TOINT]) begin
      w_in_unit = UNIT_TINT;
    end
  end

  // Only FMA and FAST results share the pipelined FP writeback port.
  assign w_pipelined = sigs_q[SIG_WEN] && (unit_q == UNIT_FMA || unit_q == UNIT_FAST);
  assign w_sched_hit = (unit_q == UNIT_FMA) ? sched_q[FMA_LAT] : sched_q[FAST_LAT];
  assign w_hazard    = ((unit_q == UNIT_DIV) && !io_divsqrt_rdy) || (w_pipelined && w_sched_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_capture) begin
      state_d = HOLD_FULL;
    end else if (w_fire || io_kill) begin
      state_d = HOLD_EMPTY;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held.
  always_comb begin
    w_fire      = (state_q == HOLD_FULL) && !w_hazard && !io_kill;
    io_in_ready = reset && !io_kill && ((state_q == HOLD_EMPTY) || w_fire);
    w_capture   = io_in_valid && io_in_ready;
  end

  always_comb begin
    inst_d  = inst_q;
    sigs_d  = sigs_q;
    unit_d  = unit_q;
    sched_d = sched_q >> 1;
    stall_d = stall_q;
    if (w_capture) begin
      inst_d = io_in_inst;
      sigs_d = io_in_sigs;
      unit_d = w_in_unit;
    end
    if (w_fire && w_pipelined) begin
      if (unit_q == UNIT_FMA) begin
        sched_d[FMA_LAT-1] = 1'b1;
      end else begin
        sched_d[FAST_LAT-1] = 1'b1;
      end
    end
    if ((state_q == HOLD_FULL) && !w_fire && !io_kill && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_q  <= '0;
      sigs_q  <= '0;
      unit_q  <= UNIT_FMA;
      sched_q <= '0;
      stall_q <= '0;
    end else begin
      inst_q  <= inst_d;
      sigs_q  <= sigs_d;
      unit_q  <= unit_d;
      sched_q <= sched_d;
      stall_q <= stall_d;
    end
  end

  assign io_iss_valid   = w_fire;
  assign io_iss_unit    = unit_q;
  assign io_iss_inst    = inst_q;
  assign io_iss_sigs    = sigs_q;
  assign io_wb_port_bsy = sched_q[0];
  assign io_stall_cnt   = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
// ============================================================================
// tb_fpu_issue_ctrl : directed scenarios plus randomized run against a
//                     cycle-indexed writeback-port model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_issue_ctrl;

  localparam int FMA_LAT  = 3;
  localparam int FAST_LAT = 2;
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [13:0] SIG_FADD  = 14'h2008;  // wen|fma
  localparam logic [13:0] SIG_FAST  = 14'h2010;  // wen|fastpipe
  localparam logic [13:0] SIG_FDIV  = 14'h2004;  // wen|div
  localparam logic [13:0] SIG_TOINT = 14'h3020;  // wen|ren1|toint

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [13:0]      in_sigs;
  logic             kill;
  logic             dsrdy;
  logic             iss_valid;
  logic [1:0]       iss_unit;
  logic [31:0]      iss_inst;
  logic [13:0]      iss_sigs;
  logic             wb_bsy;
  logic [CNT_W-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_issue_ctrl #(.FMA_LAT(FMA_LAT), .FAST_LAT(FAST_LAT), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (in_valid),
    .io_in_ready    (in_ready),
    .io_in_inst     (in_inst),
    .io_in_sigs     (in_sigs),
    .io_kill        (kill),
    .io_divsqrt_rdy (dsrdy),
    .io_iss_valid   (iss_valid),
    .io_iss_unit    (iss_unit),
    .io_iss_inst    (iss_inst),
    .io_iss_sigs    (iss_sigs),
    .io_wb_port_bsy (wb_bsy),
    .io_stall_cnt   (stall_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [1:0] unit_of(input logic [13:0] s);
    if (s[2] || s[1]) return 2'd2;
    if (s[3])         return 2'd0;
    if (s[5])         return 2'd3;
    return 2'd1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_sigs = '0; kill = 1'b0; dsrdy = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_inst = 32'h00b57553; in_sigs = SIG_FADD; kill = 1'b0; dsrdy = 1'b1;
    repeat (2) begin
      @(negedge clock);
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || iss_valid !== 1'b0 || stall_cnt !== '0 || wb_bsy !== 1'b0 || iss_unit !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state: ready=%b iss=%b stall=%0d wb=%b unit=%0d, required 0 0 0 0 0",
                 in_ready, iss_valid, stall_cnt, wb_bsy, iss_unit);
      end
    end
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_fma();
    do_reset();
    @(negedge clock);
    in_valid = 1'b1; in_inst = 32'h00b57553; in_sigs = SIG_FADD;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fma_accept: ready=%b iss=%b, required 1 0", in_ready, iss_valid);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (iss_valid !== (k == 1) || wb_bsy !== (k == 4)) begin
        n_fail++;
        $display("FAIL fma_timing t%0d: iss=%b wb=%b, required %b %b", k, iss_valid, wb_bsy, k == 1, k == 4);
      end
      if (k == 1) begin
        n_tests++;
        if (iss_unit !== 2'd0 || iss_inst !== 32'h00b57553 || iss_sigs !== SIG_FADD) begin
          n_fail++;
          $display("FAIL fma_issue_data: unit=%0d inst=%h sigs=%h, required 0 00b57553 %h",
                   iss_unit, iss_inst, iss_sigs, SIG_FADD);
        end
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      in_valid = (k <= 1);
      in_sigs  = (k == 0) ? SIG_FADD : SIG_FAST;
      in_inst  = (k == 0) ? 32'h00b57553 : 32'h20b50553;
      #1;
      n_tests++;
      if (iss_valid !== (k == 1 || k == 3) || wb_bsy !== (k == 4 || k == 5)) begin
        n_fail++;
        $display("FAIL conflict_timing t%0d: iss=%b wb=%b, required %b %b",
                 k, iss_valid, wb_bsy, (k == 1 || k == 3), (k == 4 || k == 5));
      end
      if (k == 2) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL conflict_stall_ready: got %b required 0", in_ready);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (iss_unit !== 2'd1 || iss_inst !== 32'h20b50553) begin
          n_fail++;
          $display("FAIL conflict_fast_issue: unit=%0d inst=%h, required 1 20b50553", iss_unit, iss_inst);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (stall_cnt !== 4'd1) begin
          n_fail++;
          $display("FAIL conflict_stall_cnt: got %0d required 1", stall_cnt);
        end
      end
    end
  endtask

  task automatic test_divsqrt();
    do_reset();
    @(negedge clock);
    in_valid = 1'b1; in_inst = 32'h18b57553; in_sigs = SIG_FDIV; dsrdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_inst = 32'hdeadbeef; in_sigs = SIG_FAST;
      #1;
      n_tests++;
      if (iss_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL div_wait t%0d: iss=%b ready=%b, required 0 0", k, iss_valid, in_ready);
      end
    end
    @(negedge clock);
    in_valid = 1'b0; dsrdy = 1'b1;
    #1;
    n_tests++;
    if (stall_cnt !== 4'd5 || iss_valid !== 1'b1 || iss_unit !== 2'd2 || iss_inst !== 32'h18b57553) begin
      n_fail++;
      $display("FAIL div_release: stall=%0d iss=%b unit=%0d inst=%h, required 5 1 2 18b57553",
               stall_cnt, iss_valid, iss_unit, iss_inst);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if (iss_valid !== 1'b0 || stall_cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL div_after: iss=%b stall=%0d, required 0 5", iss_valid, stall_cnt);
    end
  endtask

  task automatic test_kill();
    do_reset();
    @(negedge clock);
    in_valid = 1'b1; in_inst = 32'h00b57553; in_sigs = SIG_FADD; dsrdy = 1'b1;
    @(negedge clock);
    in_valid = 1'b1; in_inst = 32'h18b57553; in_sigs = SIG_FDIV; dsrdy = 1'b0;
    #1;
    n_tests++;
    if (iss_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_pre_issue: iss=%b required 1", iss_valid);
    end
    @(negedge clock);
    kill = 1'b1; in_valid = 1'b1; in_inst = 32'hcafef00d; in_sigs = SIG_FAST;
    #1;
    n_tests++;
    if (iss_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_cycle: iss=%b ready=%b, required 0 0", iss_valid, in_ready);
    end
    @(negedge clock);
    kill = 1'b0; in_valid = 1'b0; dsrdy = 1'b1;
    #1;
    n_tests++;
    if (iss_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL kill_after: iss=%b ready=%b stall=%0d, required 0 1 0", iss_valid, in_ready, stall_cnt);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if (wb_bsy !== 1'b1 || iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_sched_drain: wb=%b iss=%b, required 1 0", wb_bsy, iss_valid);
    end
  endtask

  task automatic test_saturation_toint();
    do_reset();
    @(negedge clock);
    in_valid = 1'b1; in_inst = 32'h18b57553; in_sigs = SIG_FDIV; dsrdy = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      if (k == 16 || k == 21) begin
        n_tests++;
        if (stall_cnt !== CNT_MAX) begin
          n_fail++;
          $display("FAIL stall_saturate t%0d: got %0d required %0d", k, stall_cnt, CNT_MAX);
        end
      end
    end
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0; in_valid = 1'b1; in_inst = 32'he0050553; in_sigs = SIG_TOINT;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (iss_valid !== 1'b1 || iss_unit !== 2'd3 || iss_inst !== 32'he0050553) begin
      n_fail++;
      $display("FAIL toint_issue: iss=%b unit=%0d inst=%h, required 1 3 e0050553", iss_valid, iss_unit, iss_inst);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      n_tests++;
      if (wb_bsy !== 1'b0 || stall_cnt !== CNT_MAX) begin
        n_fail++;
        $display("FAIL toint_no_sched t%0d: wb=%b stall=%0d, required 0 %0d", k, wb_bsy, stall_cnt, CNT_MAX);
      end
    end
  endtask

  // Reference: writeback port occupancy tracked as a set of absolute cycle numbers.
  task automatic test_random();
    bit          busy[int];
    bit          m_hold;
    logic [31:0] m_inst;
    logic [13:0] m_sigs;
    logic [1:0]  m_unit;
    int          m_stall;
    int          lat;
    bit          haz, fire, rdy_e, wb_e;
    logic [13:0] s;
    do_reset();
    m_hold = 0; m_inst = '0; m_sigs = '0; m_unit = 2'd0; m_stall = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clock);
      s = 14'($urandom);
      s[5] = 1'b0; s[3:1] = 3'b000;
      case ($urandom_range(0, 3))
        0: s[3] = 1'b1;
        1: s[4] = 1'b1;
        2: s[$urandom_range(1, 2)] = 1'b1;
        default: s[5] = 1'b1;
      endcase
      s[13]    = ($urandom_range(0, 3) != 0);
      in_sigs  = s;
      in_inst  = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      kill     = ($urandom_range(0, 11) == 0);
      dsrdy    = ($urandom_range(0, 2) != 0);
      #1;
      lat   = (m_unit == 2'd0) ? FMA_LAT : FAST_LAT;
      haz   = (m_unit == 2'd2 && !dsrdy) || (m_sigs[13] && m_unit <= 2'd1 && busy.exists(t + lat));
      fire  = m_hold && !haz && !kill;
      rdy_e = !kill && (!m_hold || fire);
      wb_e  = busy.exists(t);
      n_tests++;
      if (iss_valid !== fire || in_ready !== rdy_e || wb_bsy !== wb_e || stall_cnt !== CNT_W'(m_stall)) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d: iss=%b ready=%b wb=%b stall=%0d, required %b %b %b %0d",
                 t, iss_valid, in_ready, wb_bsy, stall_cnt, fire, rdy_e, wb_e, m_stall);
      end
      n_tests++;
      if (iss_inst !== m_inst || iss_sigs !== m_sigs || iss_unit !== m_unit) begin
        n_fail++;
        $display("FAIL rand_data cyc=%0d: inst=%h sigs=%h unit=%0d, required %h %h %0d",
                 t, iss_inst, iss_sigs, iss_unit, m_inst, m_sigs, m_unit);
      end
      if (fire && m_sigs[13] && m_unit <= 2'd1) busy[t + lat] = 1'b1;
      if (m_hold && !fire && !kill && m_stall < int'(CNT_MAX)) m_stall++;
      if (in_valid && rdy_e) begin
        m_hold = 1; m_inst = in_inst; m_sigs = in_sigs; m_unit = unit_of(in_sigs);
      end else if (fire || kill) begin
        m_hold = 0;
      end
    end
    in_valid = 1'b0; kill = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fma();
    test_conflict();
    test_divsqrt();
    test_kill();
    test_saturation_toint();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
